pwm_duty_meter_ctrl: RTL and testbench
======================================

Name: pwm_duty_meter_ctrl

Overview:
- Sequences the gated PWM counter that measures comparator on-time against the triangle-wave period.
- Synchronises the period-sync square wave (high on the rising triangle slope) and the comparator output into the clk domain.
- Counts comparator-high cycles and total cycles per triangle period, then publishes both counts through a valid/ack handshake.
- Sits between the clock/comparator sources and the downstream duty-cycle consumer.

Parameters:
- WIDTH, 16: bit width of both counters and of the result outputs.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 runs measurements, 0 forces IDLE.
- sync_in  input  1  asynchronous triangle-period square wave; a rising edge marks the period start.
- comp_in  input  1  asynchronous comparator output; 1 means the counter is enabled.
- result_ack  input  1  consumer acknowledge, sampled while result_valid=1.
- on_count  output  WIDTH  comparator-high cycles in the last complete period.
- period_count  output  WIDTH  total clk cycles in the last complete period.
- result_valid  output  1  on_count/period_count hold an unacknowledged result.
- busy  output  1  1 while in MEASURE.
- overrun  output  1  sticky; a result was overwritten before it was acked.
- timeout  output  1  sticky; a period exceeded counter range.

Behaviour:
- Reset (asynchronous, any time): every register and output goes to 0 and the state goes to IDLE. Synchroniser chains also clear.
- Input path:
  - sync_s and comp_s are the SYNC_STAGES-flop synchronised versions of sync_in and comp_in.
  - sync_d is sync_s delayed one cycle.
  - sync_rise = sync_s & ~sync_d.
  - Input-to-internal latency is SYNC_STAGES cycles.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: counters held at 0. If enable=1, go to ARM next cycle.
  - ARM: wait for sync_rise. On sync_rise, go to MEASURE with per_cnt<=1 and on_cnt<=comp_s. No result is produced from ARM.
  - MEASURE, no sync_rise: per_cnt+=1 and on_cnt+=comp_s.
  - MEASURE, sync_rise: capture on_count<=on_cnt and period_count<=per_cnt. Restart with per_cnt<=1 and on_cnt<=comp_s; the rise cycle belongs to the new period. A period of P clocks therefore yields period_count=P.
  - MEASURE timeout: if per_cnt equals 2^WIDTH-1 and there is no sync_rise, set timeout=1, go to ARM, and capture nothing. on_cnt never exceeds per_cnt, so no separate on_cnt overflow exists.
  - enable=0 in any state: go to IDLE next cycle, discard partial counts, and clear timeout and overrun. result_valid and the result data are retained.
- Handshake:
  - result_valid rises the cycle after a capture. Data stays stable while result_valid=1.
  - result_ack=1 with result_valid=1 and no capture in the same cycle: result_valid goes to 0 next cycle.
  - Capture while result_valid=1 and result_ack=0: data is overwritten, result_valid stays 1, and overrun is set.
  - Capture with result_ack=1 in the same cycle: new data loads, result_valid stays 1, and overrun is unchanged.
  - result_ack while result_valid=0 is ignored.
- busy = (state==MEASURE), registered from state.
- All arithmetic is unsigned WIDTH-bit.

Test Plan:
- Period and duty: sync_in period 100 clk, comp_in high 30 clk per period, enable=1.
  - Required: 1 clk after the second synchronised rise, result_valid=1, on_count=30, period_count=100.
  - Required: result_valid stays 1 until result_ack, then drops the next cycle.
- Duty extremes: comp_in held at 1, then held at 0, same 100-clk period.
  - Required: on_count=100 and period_count=100 with comp_in=1.
  - Required: on_count=0 and period_count=100 with comp_in=0.
- Overrun: no ack over three periods.
  - Required: overrun=1; data equals the latest period.
  - Required: ack together with a capture produces no new overrun, and result_valid stays 1.
- Timeout: WIDTH=8, one sync rise, then sync_in held low.
  - Required: after 255 cycles in MEASURE, timeout=1, busy=0, state=ARM, result_valid unchanged.
  - Required: enable low clears timeout.
- Reset mid-MEASURE: assert reset asynchronously between clock edges.
  - Required: all outputs 0 immediately.
  - Required: after release with enable=1, IDLE then ARM; the first rise yields no result, the second yields a correct result.
- Enable drop mid-period: enable=0 at cycle 50 of a period, re-enable at cycle 80.
  - Required: IDLE, no capture, partial counts discarded.
  - Required: correct on_count/period_count after two subsequent rises.

Source files
------------

// File: rtl/pwm_duty_meter_ctrl.sv
// PWM duty meter controller: synchronises the triangle-period square wave and the
// comparator, counts on-time and period length, and hands results over valid/ack.
module pwm_duty_meter_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_in,
  input  logic             comp_in,
  input  logic             result_ack,
  output logic [WIDTH-1:0] on_count,
  output logic [WIDTH-1:0] period_count,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_ff_q;
  logic [SYNC_STAGES-1:0] comp_ff_q;
  logic                   sync_d_q;
  logic                   sync_s;
  logic                   comp_s;
  logic                   sync_rise;
  logic [WIDTH-1:0]       comp_ext;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] on_cnt_q, on_cnt_d;
  logic [WIDTH-1:0] on_count_q, on_count_d;
  logic [WIDTH-1:0] period_count_q, period_count_d;
  logic             result_valid_q, result_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             busy_q;
  logic             capture;
  logic             flags_clr;

  assign sync_s    = sync_ff_q[SYNC_STAGES-1];
  assign comp_s    = comp_ff_q[SYNC_STAGES-1];
  assign sync_rise = sync_s & ~sync_d_q;
  assign comp_ext  = {{(WIDTH-1){1'b0}}, comp_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff_q <= '0;
      comp_ff_q <= '0;
      sync_d_q  <= 1'b0;
    end else begin
      sync_ff_q <= {sync_ff_q[SYNC_STAGES-2:0], sync_in};
      comp_ff_q <= {comp_ff_q[SYNC_STAGES-2:0], comp_in};
      sync_d_q  <= sync_s;
    end
  end

  // A rise both closes the running period and counts as cycle 1 of the next one.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    on_cnt_d  = on_cnt_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    flags_clr = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      per_cnt_d = CNT_ZERO;
      on_cnt_d  = CNT_ZERO;
      timeout_d = 1'b0;
      flags_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          per_cnt_d = CNT_ZERO;
          on_cnt_d  = CNT_ZERO;
          state_d   = ARM;
        end
        ARM: begin
          if (sync_rise) begin
            state_d   = MEASURE;
            per_cnt_d = CNT_ONE;
            on_cnt_d  = comp_ext;
          end else begin
            per_cnt_d = CNT_ZERO;
            on_cnt_d  = CNT_ZERO;
          end
        end
        MEASURE: begin
          if (sync_rise) begin
            capture   = 1'b1;
            per_cnt_d = CNT_ONE;
            on_cnt_d  = comp_ext;
          end else if (per_cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            per_cnt_d = CNT_ZERO;
            on_cnt_d  = CNT_ZERO;
          end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
            on_cnt_d  = on_cnt_q + comp_ext;
          end
        end
        default: begin
          state_d   = IDLE;
          per_cnt_d = CNT_ZERO;
          on_cnt_d  = CNT_ZERO;
        end
      endcase
    end
  end

  // An ack coinciding with a capture is consumed by the new result, so no overrun.
  always_comb begin
    on_count_d     = on_count_q;
    period_count_d = period_count_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    if (capture) begin
      on_count_d     = on_cnt_q;
      period_count_d = per_cnt_q;
      result_valid_d = 1'b1;
      if (result_valid_q && !result_ack) begin
        overrun_d = 1'b1;
      end
    end else if (result_valid_q && result_ack) begin
      result_valid_d = 1'b0;
    end
    if (flags_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      per_cnt_q      <= '0;
      on_cnt_q       <= '0;
      on_count_q     <= '0;
      period_count_q <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      on_cnt_q       <= on_cnt_d;
      on_count_q     <= on_count_d;
      period_count_q <= period_count_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
      busy_q         <= (state_d == MEASURE);
    end
  end

  assign on_count     = on_count_q;
  assign period_count = period_count_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pwm_duty_meter_ctrl.sv
// Bench for pwm_duty_meter_ctrl: table of period/duty vectors checked through a
// scoreboard, plus hand sequences for hold/ack, overrun, timeout, reset and enable drop.
module tb_pwm_duty_meter_ctrl;

  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sync_in;
  logic         comp_in;
  logic         result_ack;
  logic         ack_auto;
  logic         ack_man;
  logic [W-1:0] on_count;
  logic [W-1:0] period_count;
  logic         result_valid;
  logic         busy;
  logic         overrun;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en   = 1'b0;
  bit auto_ack = 1'b0;

  typedef struct { int on_c; int per_c; int at_cyc; } exp_t;
  typedef struct { int plen; int on_len; int exp_on; int exp_per; } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  assign result_ack = ack_auto | ack_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_duty_meter_ctrl #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sync_in      (sync_in),
    .comp_in      (comp_in),
    .result_ack   (result_ack),
    .on_count     (on_count),
    .period_count (period_count),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One triangle period: sync high for the first half, comparator high for on_len cycles.
  task automatic drive_period(input int plen, input int on_len, input bit push,
                              input int exp_on, input int exp_per);
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      if (i == 0 && push) sb.push_back('{exp_on, exp_per, cyc + plen + LAT});
      sync_in = (i < plen / 2);
      comp_in = (i < on_len);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    ack_auto   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ack_auto = 1'b0;
      if (mon_en && result_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got on=%0d per=%0d expected no result", on_count, period_count);
        end else begin
          e = sb.pop_front();
          chk("sb_on_count", on_count, e.on_c);
          chk("sb_period_count", period_count, e.per_c);
          chk("sb_latency_cycle", cyc, e.at_cyc);
        end
        if (auto_ack) ack_auto = 1'b1;
      end
      prev_valid = result_valid;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0;
    int tcyc;
    reset   = 1'b1;
    enable  = 1'b0;
    sync_in = 1'b0;
    comp_in = 1'b0;
    ack_man = 1'b0;

    vecs[0] = '{100,  30,  30, 100};
    vecs[1] = '{100, 100, 100, 100};
    vecs[2] = '{100,   0,   0, 100};
    vecs[3] = '{ 60,  45,  45,  60};
    vecs[4] = '{  7,   3,   3,   7};
    vecs[5] = '{  2,   1,   1,   2};
    vecs[6] = '{255, 128, 128, 255};

    #12;
    chk("rst_on_count", on_count, 0);
    chk("rst_period_count", period_count, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven periods, auto-acked, checked by the scoreboard
    mon_en   = 1'b1;
    auto_ack = 1'b1;
    enable   = 1'b1;
    repeat (4) @(negedge clk);
    chk("arm_not_busy", busy, 0);
    foreach (vecs[k]) drive_period(vecs[k].plen, vecs[k].on_len, 1'b1, vecs[k].exp_on, vecs[k].exp_per);
    drive_period(10, 0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    chk("table_sb_drained", sb.size(), 0);
    chk("table_busy", busy, 1);
    chk("table_no_timeout", timeout, 0);
    chk("table_no_overrun", overrun, 0);

    // Result held until ack, drops the cycle after ack
    enable = 1'b0;
    repeat (3) @(negedge clk);
    auto_ack = 1'b0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    drive_period(100, 30, 1'b1, 30, 100);
    fork
      drive_period(100, 50, 1'b0, 0, 0);
      begin
        repeat (40) @(negedge clk);
        chk("hold_valid", result_valid, 1);
        chk("hold_on", on_count, 30);
        chk("hold_per", period_count, 100);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        chk("ack_drop", result_valid, 0);
      end
    join
    chk("hold_sb_drained", sb.size(), 0);

    // Overrun across three unacked periods
    mon_en = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    drive_period(100, 30, 1'b0, 0, 0);
    drive_period(100, 50, 1'b0, 0, 0);
    chk("ovr_first_valid", result_valid, 1);
    chk("ovr_first_on", on_count, 30);
    chk("ovr_first_no_overrun", overrun, 0);
    drive_period(100, 70, 1'b0, 0, 0);
    drive_period(20, 0, 1'b0, 0, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", result_valid, 1);
    chk("ovr_on_latest", on_count, 70);
    chk("ovr_per_latest", period_count, 100);

    // Enable low clears overrun but keeps the result
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_clr_overrun", overrun, 0);
    chk("en_keep_valid", result_valid, 1);
    chk("en_keep_on", on_count, 70);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    drive_period(40, 10, 1'b0, 0, 0);
    chk("arm_rise_no_capture", on_count, 70);
    fork
      drive_period(20, 0, 1'b0, 0, 0);
      begin
        repeat (3) @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
      end
    join
    chk("ackcap_valid", result_valid, 1);
    chk("ackcap_on", on_count, 10);
    chk("ackcap_per", period_count, 40);
    chk("ackcap_no_overrun", overrun, 0);

    // Timeout: one rise, then sync held low
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    sync_in = 1'b1;
    c0 = cyc;
    repeat (5) @(negedge clk);
    sync_in = 1'b0;
    tcyc = -1;
    for (int k = 0; k < 400 && tcyc < 0; k++) begin
      @(negedge clk);
      if (k == 100) chk("to_busy_mid", busy, 1);
      if (timeout) tcyc = cyc;
    end
    chk("to_cycle", tcyc, c0 + 258);
    chk("to_busy", busy, 0);
    chk("to_valid_kept", result_valid, 1);
    chk("to_on_kept", on_count, 10);
    sync_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_rearm_busy", busy, 1);
    chk("to_sticky", timeout, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_clr", timeout, 0);
    chk("to_idle_busy", busy, 0);

    // Asynchronous reset mid-MEASURE
    sync_in = 1'b0;
    enable  = 1'b1;
    repeat (4) @(negedge clk);
    sync_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", result_valid, 0);
    chk("arst_on", on_count, 0);
    chk("arst_per", period_count, 0);
    chk("arst_busy", busy, 0);
    sync_in = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    mon_en   = 1'b1;
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    drive_period(100, 30, 1'b1, 30, 100);
    drive_period(10, 0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    chk("rst_sb_drained", sb.size(), 0);

    // Enable dropped at cycle 50, restored at cycle 80
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    fork
      drive_period(100, 30, 1'b0, 0, 0);
      begin
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_idle_busy", busy, 0);
        repeat (25) @(negedge clk);
        enable = 1'b1;
      end
    join
    drive_period(100, 60, 1'b1, 60, 100);
    drive_period(100, 20, 1'b1, 20, 100);
    drive_period(10, 0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    chk("drop_sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
